// File: rtl/seq_signed_divider_pkg.sv
// div_pkg: shared state encoding, default width and saturation constants for the signed divider.
package div_pkg;
    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] QMAX = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [DIV_W-1:0] QMIN = {1'b1, {(DIV_W-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/seq_signed_divider_if.sv
// seq_signed_divider_if: operand/result valid-ready bundle between a requester and the divider.
interface seq_signed_divider_if import div_pkg::*; #(parameter int W = DIV_W);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           err_div0;
    logic           err_ovf;
    logic           busy;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, err_div0, err_ovf, busy
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, err_div0, err_ovf, busy
    );
endinterface

// File: rtl/seq_signed_divider_step.sv
// div_step: one combinational restoring-division step on magnitudes.
module div_step import div_pkg::*; #(parameter int W = DIV_W) (
    input  logic [W-1:0] i_p,
    input  logic         i_bit,
    input  logic [W-1:0] i_dmag,
    output logic [W-1:0] o_p,
    output logic         o_qbit
);
    logic [W:0] w_sh;
    always_comb begin
        w_sh   = {i_p, i_bit};
        o_qbit = w_sh >= {1'b0, i_dmag};
        // i_p < i_dmag always, so the restored value fits back into W bits
        o_p    = W'(o_qbit ? w_sh - {1'b0, i_dmag} : w_sh);
    end
endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: 2W/W signed divider, radix-2 restoring on magnitudes with sign fix-up and saturating errors.
module seq_signed_divider import div_pkg::*; #(
    parameter int W     = DIV_W,
    parameter int CNT_W = $clog2(W) + 1
) (
    input logic                clk,
    input logic                rst_n,
    seq_signed_divider_if.slave bus
);
    localparam logic [W-1:0] L_QMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] L_QMIN = {1'b1, {(W-1){1'b0}}};

    state_t           r_state, w_next;
    logic [2*W-1:0]   r_dividend;
    logic [W-1:0]     r_divisor, r_dmag, r_nlo, r_p, r_q, r_quot, r_rem;
    logic             r_qneg, r_rneg, r_div0, r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   w_nmag;
    logic [W-1:0]     w_dmag, w_p;
    logic             w_qbit, w_div0, w_eovf, w_qneg, w_lovf;

    always_comb begin
        w_nmag = r_dividend[2*W-1] ? -r_dividend : r_dividend;
        w_dmag = r_divisor[W-1] ? -r_divisor : r_divisor;
        w_div0 = r_divisor == '0;
        w_eovf = !w_div0 && (w_nmag[2*W-1:W] >= w_dmag);
        w_qneg = r_dividend[2*W-1] ^ r_divisor[W-1];
        w_lovf = r_q > (r_qneg ? L_QMIN : L_QMAX);
    end

    // Upper dividend half seeds P; the early-overflow check guarantees it is below dmag
    div_step #(.W(W)) u_step (
        .i_p    (r_p),
        .i_bit  (r_nlo[W-1]),
        .i_dmag (r_dmag),
        .o_p    (w_p),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? PREP : IDLE;
            PREP:    w_next = (w_div0 || w_eovf) ? DONE : ITER;
            ITER:    w_next = (r_cnt == CNT_W'(W-1)) ? FIX : ITER;
            FIX:     w_next = DONE;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = rst_n && r_state == IDLE;
        bus.busy      = r_state != IDLE;
        bus.out_valid = r_state == DONE;
        bus.quotient  = r_quot;
        bus.remainder = r_rem;
        bus.err_div0  = r_div0;
        bus.err_ovf   = r_ovf;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_dmag     <= '0;
            r_nlo      <= '0;
            r_p        <= '0;
            r_q        <= '0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_dividend <= bus.dividend;
                    r_divisor  <= bus.divisor;
                end
                PREP: begin
                    r_p    <= w_nmag[2*W-1:W];
                    r_nlo  <= w_nmag[W-1:0];
                    r_dmag <= w_dmag;
                    r_qneg <= w_qneg;
                    r_rneg <= r_dividend[2*W-1];
                    r_cnt  <= '0;
                    r_div0 <= w_div0;
                    r_ovf  <= w_eovf;
                    r_rem  <= '0;
                    // Division by zero saturates toward the dividend's sign, zero counting positive
                    r_quot <= w_div0 ? (r_dividend[2*W-1] ? L_QMIN : L_QMAX) :
                              w_eovf ? (w_qneg ? L_QMIN : L_QMAX) : '0;
                end
                ITER: begin
                    r_p   <= w_p;
                    r_nlo <= r_nlo << 1;
                    r_q   <= {r_q[W-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_ovf  <= w_lovf;
                    r_quot <= w_lovf ? (r_qneg ? L_QMIN : L_QMAX) : (r_qneg ? -r_q : r_q);
                    r_rem  <= w_lovf ? '0 : (r_rneg ? -r_p : r_p);
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: directed and randomised checks of the sequential signed divider.
module tb_seq_signed_divider;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_signed_divider_if #(.W(16)) bus ();
    seq_signed_divider #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  lat;
    bit  all_busy;

    task automatic do_op(input logic [31:0] n, input logic [15:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        all_busy = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
            all_busy &= bus.busy;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic e0, input logic eo);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_q"}, bus.quotient, q);
        chk({tag, "_r"}, bus.remainder, r);
        chk({tag, "_err"}, {bus.err_div0, bus.err_ovf}, {e0, eo});
    endtask

    task automatic ref_div(input logic [31:0] n32, input logic [15:0] d16,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic e0, output logic eo);
        longint n, d, tq, tr;
        n = longint'($signed(n32));
        d = longint'($signed(d16));
        e0 = 1'b0;
        eo = 1'b0;
        r  = '0;
        if (d == 0) begin
            e0 = 1'b1;
            q  = (n < 0) ? 16'h8000 : 16'h7FFF;
        end else begin
            tq = n / d;
            tr = n % d;
            if (tq > 32767 || tq < -32768) begin
                eo = 1'b1;
                q  = (tq < 0) ? 16'h8000 : 16'h7FFF;
            end else begin
                q = 16'(tq);
                r = 16'(tr);
            end
        end
    endtask

    initial begin
        logic [15:0] rq, rr;
        logic        re0, reo;
        logic [15:0] hq;
        logic [31:0] rn;
        logic [15:0] rd;
        longint      lq, lr, ld;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_q", bus.quotient, 16'h0);
        chk("rst_errs", {bus.err_div0, bus.err_ovf}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", bus.in_ready, 1'b1);

        do_op(32'd1000, 16'd7);
        chk("t1_latency", lat, 18);
        chk("t1_busy", all_busy, 1'b1);
        expect_res("t1", 16'd142, 16'd6, 0, 0);
        ack();
        chk("t1_ack_valid", bus.out_valid, 1'b0);
        chk("t1_ack_ready", bus.in_ready, 1'b1);

        do_op(-32'sd1000, 16'd7);
        expect_res("t2a", 16'hFF72, 16'hFFFA, 0, 0);
        ack();
        do_op(32'd1000, -16'sd7);
        expect_res("t2b", 16'hFF72, 16'd6, 0, 0);
        ack();
        do_op(-32'sd1000, -16'sd7);
        expect_res("t2c", 16'd142, 16'hFFFA, 0, 0);
        ack();

        do_op(32'd5, 16'd0);
        chk("t3_latency", lat, 1);
        expect_res("t3a", QMAX, 16'd0, 1, 0);
        ack();
        do_op(-32'sd5, 16'd0);
        expect_res("t3b", QMIN, 16'd0, 1, 0);
        ack();

        do_op(32'h8000_0000, 16'd1);
        chk("t4a_latency", lat, 1);
        expect_res("t4a", 16'h8000, 16'd0, 0, 1);
        ack();
        do_op(32'h0040_0000, 16'h0080);
        chk("t4b_latency", lat, 18);
        expect_res("t4b", 16'h7FFF, 16'd0, 0, 1);
        ack();
        do_op(32'hFFC0_0000, 16'h0080);
        expect_res("t4c", 16'h8000, 16'd0, 0, 0);
        ack();

        do_op(32'd1000, 16'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.dividend = 32'd99;
            bus.divisor  = 16'd3;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            chk("t5_hold_valid", bus.out_valid, 1'b1);
            chk("t5_hold_q", bus.quotient, 16'd142);
            chk("t5_hold_r", bus.remainder, 16'd6);
            chk("t5_hold_in_ready", bus.in_ready, 1'b0);
        end
        ack();
        chk("t5_idle_valid", bus.out_valid, 1'b0);
        chk("t5_idle_ready", bus.in_ready, 1'b1);
        do_op(-32'sd1000, -16'sd7);
        expect_res("t5_b2b", 16'd142, 16'hFFFA, 0, 0);
        ack();

        do_op(32'd5000, 16'd0);
        ack();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 32'd5000;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", bus.out_valid, 1'b0);
        chk("t6_busy", bus.busy, 1'b0);
        chk("t6_qr", {bus.quotient, bus.remainder}, 32'h0);
        chk("t6_errs", {bus.err_div0, bus.err_ovf}, 2'b00);
        chk("t6_in_ready", bus.in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("t6_still_idle", bus.out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd100, 16'd10);
        expect_res("t6_after", 16'd10, 16'd0, 0, 0);
        ack();

        for (int k = 0; k < 400; k++) begin
            hq = 16'($urandom);
            case (k % 4)
                0: rn = $urandom;
                1: rn = {{16{hq[15]}}, hq};
                2: rn = {{8{hq[15]}}, hq, 8'($urandom)};
                default: rn = 32'($signed(16'($urandom)) * $signed(16'($urandom_range(0, 255))));
            endcase
            rd = (k % 37 == 0) ? 16'h0 : (k % 3 == 0) ? 16'($signed(8'($urandom))) : 16'($urandom);
            ref_div(rn, rd, rq, rr, re0, reo);
            do_op(rn, rd);
            expect_res("rnd", rq, rr, re0, reo);
            if (!bus.err_div0 && !bus.err_ovf) begin
                lq = longint'($signed(bus.quotient));
                lr = longint'($signed(bus.remainder));
                ld = longint'($signed(rd));
                chk("rnd_identity", 64'(lq * ld + lr), 64'(longint'($signed(rn))));
                chk("rnd_rem_bound", ((lr < 0 ? -lr : lr) < (ld < 0 ? -ld : ld)), 1'b1);
            end
            ack();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
